// File: rtl/sad_blk_loader_if.sv
// Row/block bus between a pixel-row producer, sad_blk_loader and sad_cal.
// Optional macro SAD_LD_ABORT_EN adds the blk_abort strobe.
interface sad_blk_loader_if;
    logic [127:0]  row_din;
    logic [127:0]  row_ref;
    logic          row_vld;
    logic          row_rdy;
    logic          sad_vld;
    logic [2047:0] din;
    logic [2047:0] refi;
    logic          cal_en;
    logic          cred_err;
`ifdef SAD_LD_ABORT_EN
    logic          blk_abort;

    modport master (
        output row_din, row_ref, row_vld, sad_vld, blk_abort,
        input  row_rdy, din, refi, cal_en, cred_err
    );
    modport slave (
        input  row_din, row_ref, row_vld, sad_vld, blk_abort,
        output row_rdy, din, refi, cal_en, cred_err
    );
`else
    modport master (
        output row_din, row_ref, row_vld, sad_vld,
        input  row_rdy, din, refi, cal_en, cred_err
    );
    modport slave (
        input  row_din, row_ref, row_vld, sad_vld,
        output row_rdy, din, refi, cal_en, cred_err
    );
`endif
endinterface

// File: rtl/sad_blk_loader.sv
// sad_blk_loader: gathers 16 pixel rows into a shadow buffer, hands the
// whole block to sad_cal with a one-cycle cal_en, and limits blocks in
// flight with a credit counter refilled by sad_vld.
// Optional macro SAD_LD_ABORT_EN adds blk_abort, which drops a partial block.
module sad_blk_loader #(
    parameter int unsigned MAX_OUT = 5
) (
    input  logic            clk,
    input  logic            rstn,
    sad_blk_loader_if.slave bus
);
    // State bits are {shadow_full, pend}.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        FILL_PEND = 2'b01,
        FULL      = 2'b10,
        STALL     = 2'b11
    } state_t;

    localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

    state_t        state_q, state_d;
    logic [3:0]    row_cnt_q, row_cnt_d;
    logic [3:0]    outst_q, outst_d;
    logic          cred_err_q, cred_err_d;
    logic [2047:0] din_q, refi_q;
    logic [127:0]  shd_din_q [16];
    logic [127:0]  shd_ref_q [16];
    logic [2047:0] shd_din_flat, shd_ref_flat;

    logic credit_ok, issue, xfer, row_rdy;
    logic abort, xfer_eff, row_acc;
    logic full_n, pend_n;

`ifdef SAD_LD_ABORT_EN
    assign abort = bus.blk_abort;
`else
    assign abort = 1'b0;
`endif

    assign credit_ok = (outst_q < MAX_OUT_W);
    assign xfer_eff  = xfer && !abort;
    assign row_acc   = bus.row_vld && row_rdy && !abort;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next state: a transfer refills the slot, an issue alone empties it,
    // the 16th accepted row marks the shadow full.
    always_comb begin
        full_n = state_q[1];
        pend_n = state_q[0];
        if (xfer_eff) begin
            full_n = 1'b0;
            pend_n = 1'b1;
        end else if (issue) begin
            pend_n = 1'b0;
        end
        if (abort) full_n = 1'b0;
        if (row_acc && (row_cnt_q == 4'd15)) full_n = 1'b1;
        state_d = state_t'({full_n, pend_n});
    end

    // Outputs decoded from registered state and credit availability.
    always_comb begin
        issue   = 1'b0;
        xfer    = 1'b0;
        row_rdy = 1'b1;
        unique case (state_q)
            EMPTY:     ;
            FILL_PEND: issue = credit_ok;
            FULL:      xfer = 1'b1;
            STALL: begin
                issue   = credit_ok;
                xfer    = credit_ok;
                row_rdy = credit_ok;
            end
            default:   ;
        endcase
    end

    // Row counter next value; wraps to 0 after the 16th row.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (abort)        row_cnt_d = 4'd0;
        else if (row_acc) row_cnt_d = row_cnt_q + 4'd1;
    end

    // Credit bookkeeping; a return with nothing outstanding is flagged.
    always_comb begin
        outst_d    = outst_q;
        cred_err_d = cred_err_q;
        if (issue && !bus.sad_vld) begin
            outst_d = outst_q + 4'd1;
        end else if (!issue && bus.sad_vld) begin
            if (outst_q == 4'd0) cred_err_d = 1'b1;
            else                 outst_d    = outst_q - 4'd1;
        end
    end

    // Counters, flags and the output block registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt_q  <= 4'd0;
            outst_q    <= 4'd0;
            cred_err_q <= 1'b0;
            din_q      <= '0;
            refi_q     <= '0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            outst_q    <= outst_d;
            cred_err_q <= cred_err_d;
            if (xfer_eff) begin
                din_q  <= shd_din_flat;
                refi_q <= shd_ref_flat;
            end
        end
    end

    // Shadow rows need no reset: row_cnt and the full flag gate their use.
    always_ff @(posedge clk) begin
        if (row_acc) begin
            shd_din_q[row_cnt_q] <= bus.row_din;
            shd_ref_q[row_cnt_q] <= bus.row_ref;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pack
            assign shd_din_flat[gi*128 +: 128] = shd_din_q[gi];
            assign shd_ref_flat[gi*128 +: 128] = shd_ref_q[gi];
        end
    endgenerate

    assign bus.row_rdy  = row_rdy;
    assign bus.cal_en   = issue;
    assign bus.din      = din_q;
    assign bus.refi     = refi_q;
    assign bus.cred_err = cred_err_q;
endmodule

// File: tb/tb_sad_blk_loader.sv
// Bench for sad_blk_loader: two instances (MAX_OUT 5 and 2), a queue-level
// reference model checked every cycle, table-driven single blocks and
// hand-written multi-cycle scenarios.
`timescale 1ns/1ps
module tb_sad_blk_loader;
    localparam int MX0 = 5;
    localparam int MX1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn;
    logic [127:0] t_din [2];
    logic [127:0] t_ref [2];
    logic         t_vld [2];
    logic         man_svld [2];
    logic         lb_en [2];
    logic [7:0]   lb_pipe [2];
`ifdef SAD_LD_ABORT_EN
    logic         t_abort [2];
`endif

    sad_blk_loader_if if0 ();
    sad_blk_loader_if if1 ();

    assign if0.row_din = t_din[0];
    assign if0.row_ref = t_ref[0];
    assign if0.row_vld = t_vld[0];
    assign if0.sad_vld = man_svld[0] | (lb_en[0] & lb_pipe[0][5]);
    assign if1.row_din = t_din[1];
    assign if1.row_ref = t_ref[1];
    assign if1.row_vld = t_vld[1];
    assign if1.sad_vld = man_svld[1] | (lb_en[1] & lb_pipe[1][5]);
`ifdef SAD_LD_ABORT_EN
    assign if0.blk_abort = t_abort[0];
    assign if1.blk_abort = t_abort[1];
`endif

    sad_blk_loader #(.MAX_OUT(MX0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(if0));
    sad_blk_loader #(.MAX_OUT(MX1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1));

    logic          o_rdy [2], o_cal [2], o_err [2], o_svld [2];
    logic [2047:0] o_din [2], o_ref [2];
    assign o_rdy[0] = if0.row_rdy;  assign o_rdy[1] = if1.row_rdy;
    assign o_cal[0] = if0.cal_en;   assign o_cal[1] = if1.cal_en;
    assign o_err[0] = if0.cred_err; assign o_err[1] = if1.cred_err;
    assign o_din[0] = if0.din;      assign o_din[1] = if1.din;
    assign o_ref[0] = if0.refi;     assign o_ref[1] = if1.refi;
    assign o_svld[0] = if0.sad_vld; assign o_svld[1] = if1.sad_vld;

    // Reference model: rows collected so far, one pending-block slot,
    // outstanding-credit integer.
    int            m_n [2];
    logic [127:0]  m_sd [2][16];
    logic [127:0]  m_sr [2][16];
    bit            m_pend [2];
    logic [2047:0] m_din [2], m_ref [2];
    int            m_out [2];
    bit            m_err [2];

    int            cyc = 0;
    int            n_tests = 0, n_fail = 0;
    int            cal_cnt [2], cal_edge [2], last_hs [2];
    int            cal_hist [2][8];
    bit            rdy_low [2], smp_rdy [2];
    logic [2047:0] cal_din [2], cal_ref [2];

    typedef struct packed {
        logic [7:0] din_base;
        logic [7:0] ref_px;
        int         dut;
        int         exp_lat;
        logic [7:0] exp_row0;
        logic [7:0] exp_row15;
    } vec_t;
    vec_t vecs [4];

    function automatic int mx_of(input int d);
        return (d == 0) ? MX0 : MX1;
    endfunction

    function automatic logic [2047:0] ramp_blk(input logic [7:0] base, input bit inv);
        logic [2047:0] b;
        logic [7:0]    px;
        for (int y = 0; y < 16; y++) begin
            px = base + 8'(y);
            if (inv) px = ~px;
            b[y*128 +: 128] = {16{px}};
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
        int bad;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            bad = 0;
            for (int y = 15; y >= 0; y--)
                if (act[y*128 +: 128] !== exp[y*128 +: 128]) bad = y;
            $display("[TB] FAIL %s: row %0d got %h expected %h (edge %0d)", nm, bad,
                     act[bad*128 +: 128], exp[bad*128 +: 128], cyc);
        end
    endtask

    // Called mid-cycle: compare the DUTs to the model, then advance the
    // model by the inputs that the coming edge will sample.
    task automatic mon();
        for (int d = 0; d < 2; d++) begin
            bit full, iss, xf, rdy, ab, acc, sv;
            if (!rstn) begin
                m_n[d] = 0; m_pend[d] = 0; m_out[d] = 0; m_err[d] = 0;
                m_din[d] = '0; m_ref[d] = '0;
            end
            full = (m_n[d] == 16);
            iss  = m_pend[d] && (m_out[d] < mx_of(d));
            xf   = full && (!m_pend[d] || iss);
            rdy  = !full || xf;
            chk($sformatf("dut%0d row_rdy", d), 64'(o_rdy[d]), 64'(rdy));
            chk($sformatf("dut%0d cal_en", d), 64'(o_cal[d]), 64'(iss));
            chk($sformatf("dut%0d cred_err", d), 64'(o_err[d]), 64'(m_err[d]));
            chk_blk($sformatf("dut%0d din", d), o_din[d], m_din[d]);
            chk_blk($sformatf("dut%0d refi", d), o_ref[d], m_ref[d]);

            if (o_cal[d] === 1'b1) begin
                cal_edge[d] = cyc + 1;
                cal_hist[d][cal_cnt[d] % 8] = cyc + 1;
                cal_cnt[d]++;
                cal_din[d] = o_din[d];
                cal_ref[d] = o_ref[d];
                $display("[TB] dut%0d block %0d issued at edge %0d din_row0=%h", d, cal_cnt[d],
                         cyc + 1, o_din[d][127:0]);
            end
            if (t_vld[d] && o_rdy[d]) last_hs[d] = cyc + 1;
            if (o_rdy[d] !== 1'b1) rdy_low[d] = 1'b1;
            smp_rdy[d] = (o_rdy[d] === 1'b1);

            if (rstn) begin
`ifdef SAD_LD_ABORT_EN
                ab = t_abort[d];
`else
                ab = 1'b0;
`endif
                sv  = o_svld[d];
                acc = t_vld[d] && rdy && !ab;
                if (iss) m_pend[d] = 1'b0;
                if (xf && !ab) begin
                    for (int y = 0; y < 16; y++) begin
                        m_din[d][y*128 +: 128] = m_sd[d][y];
                        m_ref[d][y*128 +: 128] = m_sr[d][y];
                    end
                    m_pend[d] = 1'b1;
                    m_n[d]    = 0;
                end
                if (ab) m_n[d] = 0;
                if (acc) begin
                    m_sd[d][m_n[d]] = t_din[d];
                    m_sr[d][m_n[d]] = t_ref[d];
                    m_n[d]++;
                end
                if (iss && !sv) m_out[d]++;
                else if (!iss && sv) begin
                    if (m_out[d] == 0) m_err[d] = 1'b1;
                    else               m_out[d]--;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) lb_pipe[d] = {lb_pipe[d][6:0], o_cal[d]};
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            t_vld[d] = 1'b0; man_svld[d] = 1'b0; lb_en[d] = 1'b0;
            lb_pipe[d] = 8'd0; t_din[d] = '0; t_ref[d] = '0;
`ifdef SAD_LD_ABORT_EN
            t_abort[d] = 1'b0;
`endif
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    task automatic push_row(input int d, input logic [127:0] rd, input logic [127:0] rr);
        int n;
        n = 0;
        t_vld[d] = 1'b1;
        t_din[d] = rd;
        t_ref[d] = rr;
        do begin
            tick();
            n++;
        end while (!smp_rdy[d] && n < 200);
        if (!smp_rdy[d]) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL dut%0d row handshake timeout after %0d cycles", d, n);
        end
    endtask

    task automatic pulse_svld(input int d);
        man_svld[d] = 1'b1;
        tick();
        man_svld[d] = 1'b0;
    endtask

    initial begin
        int base, d;
        logic [7:0] px;
        logic [2047:0] exp_b;

        for (int i = 0; i < 2; i++) begin
            cal_cnt[i] = 0; cal_edge[i] = 0; last_hs[i] = 0;
            rdy_low[i] = 0; smp_rdy[i] = 0;
        end
        vecs[0] = '{8'h00, 8'hFF, 0, 2, 8'h00, 8'h0F};
        vecs[1] = '{8'h00, 8'hFF, 1, 2, 8'h00, 8'h0F};
        vecs[2] = '{8'h20, 8'h01, 0, 2, 8'h20, 8'h2F};
        vecs[3] = '{8'hF8, 8'h80, 1, 2, 8'hF8, 8'h07};

        // Reset values.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst dut%0d row_rdy", i), 64'(o_rdy[i]), 64'd1);
            chk($sformatf("rst dut%0d cal_en", i), 64'(o_cal[i]), 64'd0);
            chk($sformatf("rst dut%0d cred_err", i), 64'(o_err[i]), 64'd0);
            chk_blk($sformatf("rst dut%0d din", i), o_din[i], '0);
            chk_blk($sformatf("rst dut%0d refi", i), o_ref[i], '0);
        end

        // Table-driven single blocks.
        for (int v = 0; v < 4; v++) begin
            d = vecs[v].dut;
            base = cal_cnt[d];
            for (int k = 0; k < 16; k++) begin
                px = vecs[v].din_base + 8'(k);
                push_row(d, {16{px}}, {16{vecs[v].ref_px}});
            end
            t_vld[d] = 1'b0;
            repeat (4) tick();
            chk($sformatf("vec%0d cal count", v), 64'(cal_cnt[d] - base), 64'd1);
            chk($sformatf("vec%0d latency", v), 64'(cal_edge[d] - last_hs[d]), 64'(vecs[v].exp_lat));
            chk($sformatf("vec%0d row0", v), 64'(cal_din[d][7:0]), 64'(vecs[v].exp_row0));
            chk($sformatf("vec%0d row15", v), 64'(cal_din[d][15*128 +: 8]), 64'(vecs[v].exp_row15));
            chk_blk($sformatf("vec%0d din", v), cal_din[d], ramp_blk(vecs[v].din_base, 1'b0));
            chk_blk($sformatf("vec%0d refi", v), cal_ref[d], {256{vecs[v].ref_px}});
            pulse_svld(d);
        end

        // Continuous stream with loopback on the MAX_OUT=5 instance.
        do_reset();
        lb_en[0] = 1'b1;
        base = cal_cnt[0];
        rdy_low[0] = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 16; k++) begin
                px = 8'h80 + 8'(b * 16 + k);
                push_row(0, {16{px}}, {16{~px}});
            end
        t_vld[0] = 1'b0;
        repeat (12) tick();
        chk("stream cal count", 64'(cal_cnt[0] - base), 64'd3);
        chk("stream gap 1-2", 64'(cal_hist[0][(base + 1) % 8] - cal_hist[0][base % 8]), 64'd16);
        chk("stream gap 2-3", 64'(cal_hist[0][(base + 2) % 8] - cal_hist[0][(base + 1) % 8]), 64'd16);
        chk("stream row_rdy dropped", 64'(rdy_low[0]), 64'd0);
        chk("stream cred_err", 64'(o_err[0]), 64'd0);
        chk_blk("stream last din", cal_din[0], ramp_blk(8'hA0, 1'b0));
        lb_en[0] = 1'b0;

        // Credit stall on the MAX_OUT=2 instance.
        do_reset();
        base = cal_cnt[1];
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 16; k++) begin
                px = 8'(b * 16 + k);
                push_row(1, {16{px}}, {16{~px}});
            end
        t_vld[1] = 1'b0;
        repeat (3) tick();
        chk("stall cal count", 64'(cal_cnt[1] - base), 64'd2);
        chk("stall row_rdy low", 64'(o_rdy[1]), 64'd0);
        pulse_svld(1);
        chk("stall release cal_en", 64'(o_cal[1]), 64'd1);
        chk("stall release row_rdy", 64'(o_rdy[1]), 64'd1);
        chk_blk("stall release din blk3", o_din[1], ramp_blk(8'h20, 1'b0));
        chk_blk("stall release refi blk3", o_ref[1], ramp_blk(8'h20, 1'b1));
        tick();
        chk("stall blk4 no cal_en", 64'(o_cal[1]), 64'd0);
        chk("stall blk4 row_rdy", 64'(o_rdy[1]), 64'd1);
        chk_blk("stall blk4 pending din", o_din[1], ramp_blk(8'h30, 1'b0));
        chk("stall cal count after", 64'(cal_cnt[1] - base), 64'd3);

        // Spurious result, then a normal block.
        do_reset();
        pulse_svld(0);
        chk("spurious cred_err", 64'(o_err[0]), 64'd1);
        repeat (2) tick();
        chk("spurious cred_err held", 64'(o_err[0]), 64'd1);
        base = cal_cnt[0];
        for (int k = 0; k < 16; k++) push_row(0, {16{8'h44}}, {16{8'h00}});
        t_vld[0] = 1'b0;
        repeat (4) tick();
        chk("spurious then block cal", 64'(cal_cnt[0] - base), 64'd1);
        chk_blk("spurious then block din", cal_din[0], {256{8'h44}});
        chk("spurious sticky", 64'(o_err[0]), 64'd1);

        // Reset mid-block (a credit is still outstanding from the 8'h44 block).
        for (int k = 0; k < 10; k++) push_row(0, {16{8'h77}}, {16{8'h77}});
        rstn = 1'b0;
        idle_inputs();
        #1;
        chk_blk("midrst din", o_din[0], '0);
        chk_blk("midrst refi", o_ref[0], '0);
        chk("midrst cal_en", 64'(o_cal[0]), 64'd0);
        chk("midrst cred_err", 64'(o_err[0]), 64'd0);
        chk("midrst row_rdy", 64'(o_rdy[0]), 64'd1);
        repeat (2) tick();
        rstn = 1'b1;
        pulse_svld(0);
        chk("stale credit cred_err", 64'(o_err[0]), 64'd1);
        base = cal_cnt[0];
        for (int k = 0; k < 16; k++) push_row(0, {16{8'h5A}}, {16{8'hA5}});
        t_vld[0] = 1'b0;
        repeat (4) tick();
        chk("midrst block cal", 64'(cal_cnt[0] - base), 64'd1);
        chk_blk("midrst block din", cal_din[0], {256{8'h5A}});
        chk_blk("midrst block refi", cal_ref[0], {256{8'hA5}});

`ifdef SAD_LD_ABORT_EN
        // Abort a partial block together with a live row.
        do_reset();
        base = cal_cnt[0];
        for (int k = 0; k < 7; k++) push_row(0, {16{8'h11}}, {16{8'h11}});
        t_abort[0] = 1'b1;
        push_row(0, {16{8'h11}}, {16{8'h11}});
        t_abort[0] = 1'b0;
        for (int k = 0; k < 16; k++) push_row(0, {16{8'h33}}, {16{8'h33}});
        t_vld[0] = 1'b0;
        repeat (4) tick();
        chk("abort cal count", 64'(cal_cnt[0] - base), 64'd1);
        chk_blk("abort din", cal_din[0], {256{8'h33}});
`endif

        // Randomized traffic on both instances against the model.
        do_reset();
        base = cal_cnt[0] + cal_cnt[1];
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                t_vld[i] = ($urandom_range(3) != 0);
                t_din[i] = {$urandom, $urandom, $urandom, $urandom};
                t_ref[i] = {$urandom, $urandom, $urandom, $urandom};
                if (m_out[i] > 0)
                    man_svld[i] = ($urandom_range((c < 1500) ? 39 : 7) == 0);
                else
                    man_svld[i] = ($urandom_range(199) == 0);
`ifdef SAD_LD_ABORT_EN
                t_abort[i] = ($urandom_range(63) == 0);
`endif
            end
            tick();
        end
        idle_inputs();
        tick();
        chk("random traffic issued blocks", 64'(cal_cnt[0] + cal_cnt[1] - base > 20), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
